// File: rtl/eth_tx_pkt_buf.sv
// Store-and-forward transmit buffer: packets are committed whole, then replayed
// back-to-back with a programmable idle gap; malformed or oversized packets are dropped.
module eth_tx_pkt_buf #(
    parameter int pDepth      = 2048,
    parameter int pGap_Cycles = 6400
) (
    input  logic                     Clk,
    input  logic                     Rstn,
    input  logic [9:0]               In_Byte,
    input  logic                     In_Valid,
    output logic [9:0]               Eth_Byte,
    output logic                     Eth_Byte_Valid,
    output logic [$clog2(pDepth):0]  Pkt_Count,
    output logic [15:0]              Drop_Count,
    output logic                     Drop_Pulse
);

    localparam int AW = $clog2(pDepth);
    localparam int PW = AW + 1;
    localparam int GW = (pGap_Cycles > 1) ? $clog2(pGap_Cycles + 1) : 1;

    typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_BURST, RD_GAP} rd_state_t;

    logic [9:0]    r_mem [pDepth];
    wr_state_t     r_wr_state, w_wr_state_nx;
    rd_state_t     r_rd_state;
    logic [PW-1:0] r_wr_ptr, r_wr_start, r_rd_ptr, r_pkt_count;
    logic [PW-1:0] w_base, w_wr_ptr_nx, w_wr_start_nx;
    logic [GW-1:0] r_gap_cnt;
    logic [9:0]    r_eth_byte;
    logic          r_eth_valid;
    logic [15:0]   r_drop_count;
    logic          r_drop_pulse;
    logic          w_sop, w_eop, w_full, w_we, w_drop, w_commit, w_rd_done;

    assign w_sop = In_Byte[9];
    assign w_eop = In_Byte[8];
    // A SOP inside a packet restarts at that packet's base, so space is judged from there.
    assign w_base = (r_wr_state == WR_PKT && w_sop) ? r_wr_start : r_wr_ptr;
    assign w_full = (w_base - r_rd_ptr) == PW'(pDepth);

    // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        w_we          = 1'b0;
        w_drop        = 1'b0;
        w_commit      = 1'b0;
        w_wr_state_nx = r_wr_state;
        w_wr_ptr_nx   = r_wr_ptr;
        w_wr_start_nx = r_wr_start;
        if (In_Valid) begin
            if (w_sop) begin
                w_drop = (r_wr_state == WR_PKT);
                if (!w_full) begin
                    w_we          = 1'b1;
                    w_wr_start_nx = w_base;
                    w_wr_ptr_nx   = w_base + PW'(1);
                    w_commit      = w_eop;
                    w_wr_state_nx = w_eop ? WR_IDLE : WR_PKT;
                end else begin
                    w_drop        = 1'b1;
                    w_wr_start_nx = w_base;
                    w_wr_ptr_nx   = w_base;
                    w_wr_state_nx = w_eop ? WR_IDLE : WR_DROP;
                end
            end else begin
                case (r_wr_state)
                    WR_IDLE: w_drop = 1'b1;
                    WR_PKT: begin
                        if (!w_full) begin
                            w_we        = 1'b1;
                            w_wr_ptr_nx = r_wr_ptr + PW'(1);
                            w_commit    = w_eop;
                            if (w_eop) w_wr_state_nx = WR_IDLE;
                        end else begin
                            w_drop        = 1'b1;
                            w_wr_ptr_nx   = r_wr_start;
                            w_wr_state_nx = w_eop ? WR_IDLE : WR_DROP;
                        end
                    end
                    default: if (w_eop) w_wr_state_nx = WR_IDLE;
                endcase
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are never read before being written.
    always_ff @(posedge Clk) begin
        if (w_we) r_mem[w_base[AW-1:0]] <= In_Byte;
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            r_wr_state   <= WR_IDLE;
            r_wr_ptr     <= '0;
            r_wr_start   <= '0;
            r_drop_count <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_wr_state   <= w_wr_state_nx;
            r_wr_ptr     <= w_wr_ptr_nx;
            r_wr_start   <= w_wr_start_nx;
            r_drop_pulse <= w_drop;
            if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign w_rd_done = (r_rd_state == RD_BURST) && r_eth_byte[8];

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            r_pkt_count <= '0;
        end else if (w_commit && !w_rd_done) begin
            r_pkt_count <= r_pkt_count + PW'(1);
        end else if (w_rd_done && !w_commit) begin
            r_pkt_count <= r_pkt_count - PW'(1);
        end
    end

    // The output register holds the word read in the previous cycle; it is cleared when idle.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            r_rd_state  <= RD_IDLE;
            r_rd_ptr    <= '0;
            r_gap_cnt   <= '0;
            r_eth_byte  <= '0;
            r_eth_valid <= 1'b0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (r_pkt_count != '0) begin
                        r_eth_byte  <= r_mem[r_rd_ptr[AW-1:0]];
                        r_eth_valid <= 1'b1;
                        r_rd_ptr    <= r_rd_ptr + PW'(1);
                        r_rd_state  <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (r_eth_byte[8]) begin
                        r_eth_byte  <= '0;
                        r_eth_valid <= 1'b0;
                        if (pGap_Cycles == 0) begin
                            r_rd_state <= RD_IDLE;
                        end else begin
                            r_gap_cnt  <= GW'(pGap_Cycles);
                            r_rd_state <= RD_GAP;
                        end
                    end else begin
                        r_eth_byte <= r_mem[r_rd_ptr[AW-1:0]];
                        r_rd_ptr   <= r_rd_ptr + PW'(1);
                    end
                end
                RD_GAP: begin
                    if (r_gap_cnt <= GW'(1)) r_rd_state <= RD_IDLE;
                    else                     r_gap_cnt  <= r_gap_cnt - GW'(1);
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign Eth_Byte       = r_eth_byte;
    assign Eth_Byte_Valid = r_eth_valid;
    assign Pkt_Count      = r_pkt_count;
    assign Drop_Count     = r_drop_count;
    assign Drop_Pulse     = r_drop_pulse;

endmodule

// File: doc/eth_tx_pkt_buf.md
# eth_tx_pkt_buf

Store-and-forward transmit packet buffer in the Eth_Clk domain, directly upstream of the Ethernet transmitter's 10-bit byte input (bit 9 SOP, bit 8 EOP, bits 7:0 data). It accepts payload bytes that may arrive with arbitrary gaps and holds each packet until the whole packet is stored. It then replays the packet on consecutive clock cycles, as the transmitter requires, and enforces a programmable idle gap between packets. Malformed or oversized packets are discarded whole and counted.

## Interface
Parameters:
- pDepth, 2048: byte storage depth; power of two, 16 to 65536.
- pGap_Cycles, 6400: minimum idle cycles after each output EOP before the next output SOP. 0 is legal.

Ports:
- Clk  in  1  Eth_Clk; all logic on rising edge.
- Rstn  in  1  asynchronous, active-low reset.
- In_Byte  in  10  input word: bit 9 SOP, bit 8 EOP, 7:0 data.
- In_Valid  in  1  In_Byte valid this cycle. There is no backpressure.
- Eth_Byte  out  10  output word, same format; drives transmitter Eth_Byte.
- Eth_Byte_Valid  out  1  output valid; drives transmitter Eth_Byte_Valid.
- Pkt_Count  out  $clog2(pDepth)+1  committed packets not yet fully output.
- Drop_Count  out  16  dropped-packet/stray-byte counter; saturates at 0xFFFF.
- Drop_Pulse  out  1  one-cycle pulse per drop event.

## Operation
- Storage:
  - Single-port-write / single-port-read RAM of pDepth × 10 bits.
  - Pointers wr_ptr, wr_start and rd_ptr are $clog2(pDepth)+1 bits wide, with wrap-around modulo 2·pDepth.
  - used = wr_ptr − rd_ptr, computed modulo 2·pDepth. Full when used == pDepth.
- Write FSM, WR_IDLE / WR_PKT / WR_DROP. Each item below applies only on a cycle with In_Valid=1.
  - WR_IDLE, SOP=1, not full: write the byte, set wr_start=wr_ptr, wr_ptr++.
    - If EOP=1 as well: commit the packet and stay in WR_IDLE.
    - Otherwise: go to WR_PKT.
  - WR_IDLE, SOP=0: discard the byte, count one drop.
  - WR_PKT, SOP=0, not full: write the byte, wr_ptr++. If EOP=1: commit and go to WR_IDLE.
  - WR_PKT, SOP=1: abort the current packet (wr_ptr ← wr_start) and count one drop. The new byte is then handled exactly as in WR_IDLE.
  - Any SOP or data byte while full: wr_ptr ← wr_start and count one drop.
    - If that byte had EOP=1: go to WR_IDLE.
    - Otherwise: go to WR_DROP.
  - WR_DROP: discard every byte. A byte with EOP goes to WR_IDLE. A byte with SOP is handled as in WR_IDLE.
- Commit: Pkt_Count++. Only committed bytes are ever read.
- Drop event: Drop_Pulse=1 in the next cycle, and Drop_Count += 1 unless it is already 0xFFFF.
- Read FSM, RD_IDLE / RD_BURST / RD_GAP:
  - RD_IDLE, Pkt_Count≠0: issue a RAM read at rd_ptr, rd_ptr++, go to RD_BURST.
  - RD_BURST: the registered output is valid.
    - If the output word has EOP=1: Pkt_Count−−, issue no read, go to RD_GAP (or RD_IDLE when pGap_Cycles=0).
    - Otherwise: issue the next read, rd_ptr++.
  - RD_GAP: a counter loads pGap_Cycles and decrements. At 1 it goes to RD_IDLE.
- Pkt_Count increment and decrement in the same cycle: the value is unchanged.
- Eth_Byte is forced to 0 whenever Eth_Byte_Valid=0.

## Timing
- Reset values (asynchronous) of all outputs: Eth_Byte=0, Eth_Byte_Valid=0, Pkt_Count=0, Drop_Count=0, Drop_Pulse=0.
- Reset values of internal state: both FSMs in IDLE, all pointers 0. RAM contents are don't-care.
- Latency, idle buffer: EOP sampled in cycle t → Pkt_Count≠0 in cycle t+1 (read issued) → SOP output in cycle t+2.
- Burst: Eth_Byte_Valid stays high for exactly N consecutive cycles for an N-byte packet.
  - SOP appears only on the first output word; EOP appears only on the last.
- Gap: output EOP in cycle e → RD_GAP occupies cycles e+1..e+pGap_Cycles → next SOP no earlier than cycle e+pGap_Cycles+2.
- Freeing: rd_ptr advances on each read issue, so the freed slot is writable in the following cycle.
- Reset mid-burst: output drops to 0 immediately. The partial packet and all queued packets are lost.
- A packet of exactly pDepth bytes is accepted. A packet of pDepth+1 bytes is dropped at its last byte.

## Test plan
- 60-byte packet (data 0x00–0x3B), In_Valid continuous, pGap_Cycles=16:
  - 60 consecutive valid outputs: first word 0x200, last word 0x13B.
  - SOP appears 2 cycles after the input EOP.
  - Pkt_Count goes 1 → 0.
- 20-byte packet with In_Valid every 3rd cycle: no output until the EOP is stored, then 20 consecutive valid words identical to the input.
- Two back-to-back 8-byte packets, pGap_Cycles=16: the second SOP appears exactly 18 cycles after the first output EOP. Pkt_Count peaks at 2.
- pDepth=64, empty buffer, 100-byte packet:
  - The packet is dropped: Drop_Count=1, one Drop_Pulse, no output.
  - A following 10-byte packet is output intact.
- Protocol errors:
  - 5 bytes followed by a new SOP: the first packet is dropped (Drop_Count=1) and the second is delivered.
  - A lone byte 0x055 (no SOP) in WR_IDLE: Drop_Count=2, no output.
- Rstn asserted in the middle of the output burst:
  - Outputs are 0 in the same cycle; Pkt_Count and Drop_Count are 0.
  - After release, a 4-byte packet is output correctly.
